// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : shared types for the sequential ALU (opcodes, flags, FSM states)
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_MUL  = 3'b110,
    OP_RSVD = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/adder_nbit.sv
// ============================================================================
// adder_nbit : WIDTH-bit adder with carry in and carry out
// Rev 1.0
// ============================================================================
`default_nettype none

module adder_nbit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + (WIDTH+1)'(cin_i);

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// alu_seq : registered ALU with NZCV flags, shift-add multiplier, valid/ready
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             illegal
);

  localparam int AW    = 2 * WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int MSB   = WIDTH - 1;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [AW-1:0]    acc_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_hi_q;
  flags_t           flags_q;
  logic             illegal_q;

  alu_op_e          op_e;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] res_d;
  flags_t           flg_d;
  logic             ill_d;

  logic [AW-1:0]    mul_addend;
  logic [AW-1:0]    mul_sum;
  logic             mul_cout;
  logic [AW:0]      mul_ext;
  logic [AW-1:0]    acc_d;
  flags_t           mul_flg_d;

  assign op_e     = alu_op_e'(op);
  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);

  // SUB reuses the adder as a + ~b + 1
  assign add_b   = (op_e == OP_SUB) ? ~b : b;
  assign add_cin = (op_e == OP_SUB);

  adder_nbit #(.WIDTH(WIDTH)) u_add (
    .a_i    (a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    res_d = '0;
    flg_d = '0;
    ill_d = 1'b0;
    unique case (op_e)
      OP_AND: res_d = a & b;
      OP_OR:  res_d = a | b;
      OP_XOR: res_d = a ^ b;
      OP_ADD, OP_SUB: begin
        res_d   = add_sum;
        flg_d.c = add_cout;
        flg_d.v = (a[MSB] == add_b[MSB]) && (add_sum[MSB] != a[MSB]);
      end
      OP_SHL: begin
        res_d   = {a[WIDTH-2:0], 1'b0};
        flg_d.c = a[MSB];
        flg_d.v = a[MSB] ^ a[MSB-1];
      end
      default: ill_d = (op_e == OP_RSVD);
    endcase
    if (!ill_d) begin
      flg_d.n = res_d[MSB];
      flg_d.z = (res_d == '0);
    end
  end

  // Right-shifting accumulator: multiplicand enters the top half, carry is kept
  assign mul_addend = mplier_q[0] ? {mcand_q, {WIDTH{1'b0}}} : '0;

  adder_nbit #(.WIDTH(AW)) u_mac (
    .a_i    (acc_q),
    .b_i    (mul_addend),
    .cin_i  (1'b0),
    .sum_o  (mul_sum),
    .cout_o (mul_cout)
  );

  assign mul_ext = {mul_cout, mul_sum};
  assign acc_d   = AW'(mul_ext >> 1);

  always_comb begin
    mul_flg_d   = '0;
    mul_flg_d.n = acc_d[MSB];
    mul_flg_d.z = (acc_d[WIDTH-1:0] == '0);
    mul_flg_d.c = |acc_d[AW-1:WIDTH];
    mul_flg_d.v = |acc_d[AW-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      illegal_q   <= 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (op_e == OP_MUL) begin
              state_q  <= MUL_BUSY;
              cnt_q    <= '0;
              mcand_q  <= a;
              mplier_q <= b;
              acc_q    <= '0;
            end else begin
              result_q    <= res_d;
              result_hi_q <= '0;
              flags_q     <= flg_d;
              illegal_q   <= ill_d;
              out_valid_q <= 1'b1;
            end
          end
        end
        MUL_BUSY: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q     <= IDLE;
            result_q    <= acc_d[WIDTH-1:0];
            result_hi_q <= acc_d[AW-1:WIDTH];
            flags_q     <= mul_flg_d;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags     = flags_q;
  assign illegal   = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// tb_alu_seq : directed self-checking bench for alu_seq at WIDTH=4
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic [3:0]   flags;
  logic         illegal;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flags     (flags),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Presents one operation for exactly one edge; called at posedge+1
  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [2:0] xop);
    a = xa; b = xb; op = xop; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    @(posedge clk); @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (result !== 4'h0 || result_hi !== 4'h0) begin n_fail++; $display("FAIL reset_result: got %h/%h want 0/0", result_hi, result); end
    n_checks++; if (flags !== 4'b0000 || illegal !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got %b ill %b want 0000 ill 0", flags, illegal); end
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add_sub();
    send(4'hF, 4'h1, OP_ADD);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_latency: out_valid %b want 1", out_valid); end
    n_checks++; if (result !== 4'h0 || flags !== 4'b0110) begin n_fail++; $display("FAIL add_F_1: got %h flags %b want 0 flags 0110", result, flags); end
    send(4'h5, 4'h7, OP_SUB);
    n_checks++; if (result !== 4'hE || flags !== 4'b1000) begin n_fail++; $display("FAIL sub_5_7: got %h flags %b want E flags 1000", result, flags); end
    send(4'h8, 4'h1, OP_SUB);
    n_checks++; if (result !== 4'h7 || flags !== 4'b0011) begin n_fail++; $display("FAIL sub_8_1: got %h flags %b want 7 flags 0011", result, flags); end
  endtask

  task automatic test_logic_shift();
    send(4'h6, 4'h6, OP_XOR);
    n_checks++; if (result !== 4'h0 || flags !== 4'b0100) begin n_fail++; $display("FAIL xor_6_6: got %h flags %b want 0 flags 0100", result, flags); end
    send(4'hA, 4'h0, OP_SHL);
    n_checks++; if (result !== 4'h4 || flags !== 4'b0011 || result_hi !== 4'h0) begin n_fail++; $display("FAIL shl_A: got %h flags %b hi %h want 4 flags 0011 hi 0", result, flags, result_hi); end
  endtask

  task automatic test_mul();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mul_pre_ready: got %b want 1", in_ready); end
    send(4'hF, 4'hF, OP_MUL);
    a = 4'h0; b = 4'h0; op = OP_AND;
    for (int i = 0; i < W; i++) begin
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL mul_busy_%0d: out_valid %b in_ready %b want 0 0", i, out_valid, in_ready); end
      @(posedge clk); #1;
    end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mul_latency: out_valid %b want 1", out_valid); end
    n_checks++; if (result !== 4'h1 || result_hi !== 4'hE || flags !== 4'b0011 || illegal !== 1'b0) begin n_fail++; $display("FAIL mul_F_F: got %h:%h flags %b ill %b want E:1 flags 0011 ill 0", result_hi, result, flags, illegal); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    send(4'h3, 4'h4, OP_ADD);
    out_ready = 1'b0;
    a = 4'hC; b = 4'hA; op = OP_AND; in_valid = 1'b1;
    n_checks++; if (result !== 4'h7 || result_hi !== 4'h0) begin n_fail++; $display("FAIL bp_add_3_4: got %h hi %h want 7 hi 0", result, result_hi); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 4'h7 || flags !== 4'b0000) begin n_fail++; $display("FAIL bp_hold_%0d: ov %b rdy %b res %h flags %b want 1 0 7 0000", i, out_valid, in_ready, result, flags); end
    end
    out_ready = 1'b1; #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || result !== 4'h8 || flags !== 4'b1000) begin n_fail++; $display("FAIL bp_and_C_A: ov %b res %h flags %b want 1 8 1000", out_valid, result, flags); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    a = 4'h2; b = 4'h3; op = OP_ADD; in_valid = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (result !== 4'h5 || flags !== 4'b0000) begin n_fail++; $display("FAIL b2b_add_2_3: got %h flags %b want 5 0000", result, flags); end
    a = 4'h8; b = 4'h1; op = OP_OR;
    @(posedge clk); #1;
    n_checks++; if (result !== 4'h9 || flags !== 4'b1000) begin n_fail++; $display("FAIL b2b_or_8_1: got %h flags %b want 9 1000", result, flags); end
    a = 4'h7; b = 4'h1; op = OP_ADD;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || result !== 4'h8 || flags !== 4'b1001) begin n_fail++; $display("FAIL b2b_add_7_1: ov %b res %h flags %b want 1 8 1001", out_valid, result, flags); end
  endtask

  task automatic test_reset_mid_mul();
    out_ready = 1'b1;
    send(4'h3, 4'h3, OP_MUL);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmul_state: ov %b rdy %b want 0 1", out_valid, in_ready); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0 || result !== 4'h0) begin n_fail++; $display("FAIL rstmul_no_result_%0d: ov %b res %h want 0 0", i, out_valid, result); end
    end
  endtask

  task automatic test_reserved();
    send(4'h5, 4'h3, OP_RSVD);
    n_checks++; if (out_valid !== 1'b1 || illegal !== 1'b1) begin n_fail++; $display("FAIL rsvd_illegal: ov %b ill %b want 1 1", out_valid, illegal); end
    n_checks++; if (result !== 4'h0 || result_hi !== 4'h0 || flags !== 4'b0000) begin n_fail++; $display("FAIL rsvd_zero: res %h hi %h flags %b want 0 0 0000", result, result_hi, flags); end
    send(4'h5, 4'h3, OP_OR);
    n_checks++; if (result !== 4'h7 || illegal !== 1'b0 || flags !== 4'b0000) begin n_fail++; $display("FAIL rsvd_then_or: res %h ill %b flags %b want 7 0 0000", result, illegal, flags); end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic_shift();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    test_reserved();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded 50000 time units");
    $fatal(1);
  end

endmodule

`default_nettype wire
